// File: rtl/iot_topk_filter.sv
// iot_topk_filter: byte-serial top-K / bottom-K filter.
// Bytes are packed LSB-first into W-bit words. Each round of ROUND words
// keeps a sorted K-entry list, which is drained in rank order once the
// round's last word has been inserted.
module iot_topk_filter #(
  parameter int BYTES = 16,
  parameter int ROUND = 8,
  parameter int K     = 2,
  localparam int W    = 8 * BYTES,
  localparam int RW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic [7:0]    iot_in,
  input  logic          mode_sel,
  output logic          busy,
  output logic          valid,
  output logic [W-1:0]  iot_out,
  output logic [RW-1:0] out_rank
);

  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WW = (ROUND > 1) ? $clog2(ROUND) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BYTES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(ROUND - 1);
  localparam logic [3:0]    D_LAST = 4'(K);

  // Illegal parameter combinations stop elaboration.
  generate
    if (ROUND < K) begin : g_round_check
      $error("iot_topk_filter: ROUND must be >= K");
    end
    if (K < 1 || K > 8) begin : g_k_check
      $error("iot_topk_filter: K must be in 1..8");
    end
    if (BYTES < 1 || BYTES > 32) begin : g_bytes_check
      $error("iot_topk_filter: BYTES must be in 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    RESET_EXIT,
    COLLECT,
    FLUSH,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [BW-1:0] b;
  logic [WW-1:0] w;
  logic [W-1:0]  asm_word;
  logic [W-1:0]  word_full;
  logic [W-1:0]  new_word;
  logic          ins_pending;
  logic          round_mode;

  logic [W-1:0]  entry     [K];
  logic [K-1:0]  entry_v;
  logic [W-1:0]  ins_entry [K];
  logic [K-1:0]  ins_v;
  logic [K-1:0]  take;

  logic [3:0]    drain_cnt;

  logic          accept;
  logic          word_done;
  logic          round_done;
  logic          drain_end;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_EXIT;
    else     state <= state_next;
  end

  // Next-state decode plus the per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    word_done  = 1'b0;
    round_done = 1'b0;
    drain_end  = 1'b0;
    case (state)
      RESET_EXIT: state_next = COLLECT;
      COLLECT: begin
        accept     = in_en;
        word_done  = in_en && (b == B_LAST);
        round_done = in_en && (b == B_LAST) && (w == W_LAST);
        if (round_done) state_next = FLUSH;
      end
      FLUSH: state_next = DRAIN;
      DRAIN: begin
        if (drain_cnt == D_LAST) begin
          drain_end  = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // The completed word is the assembly buffer with the final byte in the MSB slot.
  always_comb begin
    word_full = asm_word;
    word_full[W-1 -: 8] = iot_in;
  end

  // Byte/word counters, byte assembly, per-round mode latch, insertion handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b           <= '0;
      w           <= '0;
      asm_word    <= '0;
      new_word    <= '0;
      ins_pending <= 1'b0;
      round_mode  <= 1'b0;
    end else begin
      ins_pending <= word_done;
      if (accept) begin
        asm_word[{b, 3'b000} +: 8] <= iot_in;
        if ((b == '0) && (w == '0)) round_mode <= mode_sel;
        if (word_done) begin
          b        <= '0;
          new_word <= word_full;
          w        <= (w == W_LAST) ? '0 : w + 1'b1;
        end else begin
          b <= b + 1'b1;
        end
      end
    end
  end

  // An entry is displaced when empty or strictly worse; ties keep the older word.
  always_comb begin
    take = '0;
    for (int i = 0; i < K; i++) begin
      if (!entry_v[i])     take[i] = 1'b1;
      else if (round_mode) take[i] = (new_word < entry[i]);
      else                 take[i] = (new_word > entry[i]);
    end
  end

  // Because the list is sorted, take[] is a thermometer: the first set bit
  // receives the new word and every later set bit pulls from its predecessor.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      ins_entry[i] = entry[i];
      ins_v[i]     = entry_v[i];
    end
    if (take[0]) begin
      ins_entry[0] = new_word;
      ins_v[0]     = 1'b1;
    end
    for (int i = 1; i < K; i++) begin
      if (take[i]) begin
        if (!take[i-1]) begin
          ins_entry[i] = new_word;
          ins_v[i]     = 1'b1;
        end else begin
          ins_entry[i] = entry[i-1];
          ins_v[i]     = entry_v[i-1];
        end
      end
    end
  end

  // Sorted list storage: updated by each pending insertion, emptied after drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_v <= '0;
      for (int i = 0; i < K; i++) entry[i] <= '0;
    end else if (drain_end) begin
      entry_v <= '0;
    end else if (ins_pending) begin
      entry_v <= ins_v;
      for (int i = 0; i < K; i++) entry[i] <= ins_entry[i];
    end
  end

  // Registered outputs: busy window, and rank-ordered drain of the list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b1;
      valid     <= 1'b0;
      iot_out   <= '0;
      out_rank  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        RESET_EXIT: busy <= 1'b0;
        COLLECT: begin
          if (round_done) busy <= 1'b1;
        end
        FLUSH: begin
          valid     <= 1'b1;
          iot_out   <= ins_entry[0];
          out_rank  <= '0;
          drain_cnt <= 4'd1;
        end
        DRAIN: begin
          if (drain_end) begin
            valid <= 1'b0;
            busy  <= 1'b0;
          end else begin
            iot_out   <= entry[drain_cnt[RW-1:0]];
            out_rank  <= drain_cnt[RW-1:0];
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iot_topk_filter.md
Name: iot_topk_filter

Overview:
- Byte-serial IoT data filter. Assembles 8*BYTES-bit words from an 8-bit stream and groups every ROUND words into one round.
- For each round it emits the K largest (MAX mode) or K smallest (MIN mode) words, in rank order.
- Sits beside the existing function blocks on the same in_en/iot_in/busy/valid interface. It generalises the fixed two-entry max/min filter to parametrised word width, round length and K, and adds tie ordering and rank tagging.

Parameters:
- BYTES, 16, bytes per word; word width W = 8*BYTES. Legal range 1..32.
- ROUND, 8, words per round. Must be >= K; elaboration fails otherwise.
- K, 2, number of words reported per round. Legal range 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_en  in  1  iot_in carries a valid byte this cycle
- iot_in  in  8  input byte
- mode_sel  in  1  0 = MAX (top-K largest), 1 = MIN (K smallest)
- busy  out  1  block not accepting bytes; registered
- valid  out  1  iot_out/out_rank valid this cycle; registered
- iot_out  out  W  reported word
- out_rank  out  clog2(K), min 1  rank of iot_out; 0 = best

Behaviour:
- Reset values: busy=1, valid=0, iot_out=0, out_rank=0. Also cleared: byte counter b, word counter w, all list-entry valid bits. Reset mid-round or mid-drain aborts the round; no partial output follows.
- First clock after reset release: busy drops to 0, state COLLECT.
- Byte packing: the byte accepted at b lands in word bits [8b+7:8b], so the first byte is the LSB. b wraps BYTES-1 -> 0. w wraps ROUND-1 -> 0.
- in_en while busy=1: byte ignored; b and w unchanged.
- mode_sel is sampled on the first accepted byte of each round (w=0, b=0) and held for the whole round, including drain. Changes mid-round have no effect.
- The sorted list holds K entries, each a W-bit word plus a valid bit. Entry 0 is best.
- Comparison is unsigned over the full W bits.
- Insertion: cycle t is the cycle with in_en=1 at b=BYTES-1. The completed word is registered and inserted during t+1; the list updates at the end of t+1.
  - A new word enters at the first position whose entry is invalid or strictly worse than it. Lower entries shift down and entry K-1 is dropped.
  - Ties: an equal word never displaces an existing one. Earlier arrival ranks higher.
- Insertion overlaps collection of the next word. Back-to-back words with in_en=1 every cycle must be supported with no stall inside a round.
- End of round: t = last byte of word w=ROUND-1.
  - FLUSH (t+1): final insertion; busy=1.
  - DRAIN (t+2 .. t+K+1): valid=1. iot_out = entry i and out_rank = i, for i = 0..K-1 in order.
  - CLEAR: at the end of t+K+1 all entry valid bits are cleared and busy is registered low. busy=0 and bytes are accepted again from t+K+2.
- busy is high for exactly cycles t+1 .. t+K+1 (K+1 cycles) per round, and low in all other COLLECT cycles.
- Outside DRAIN: valid=0. iot_out and out_rank hold their last values (not required to be zero).
- in_en gaps are allowed anywhere inside a round. Latency is counted from the final byte, not the round start.
- No sentinel values are used, so all-zero words in MAX mode and all-ones words in MIN mode rank correctly.
- States: RESET_EXIT -> COLLECT -> FLUSH -> DRAIN(K cycles) -> COLLECT.

Test Plan:
- Defaults, MAX; round words 5,9,3,9,1,7,2,8 (values in the LSB byte, other bytes 0) -> valid for 2 cycles: (9, rank0), (9, rank1). The rank0 9 is the second word, showing tie stability. busy high 3 cycles.
- Defaults, MIN; words 128'hFF..FF x7 then 128'h0 -> outputs 0 (rank0) then all-ones (rank1). Confirms no sentinel artefacts.
- Defaults, MAX; two words differing only in byte 15 (0x80 vs 0x7F, lower bytes of the smaller word = 0xFF) -> the 0x80 word ranks 0. Confirms the full-width unsigned compare.
- BYTES=4, ROUND=5, K=3, MIN; words 40,10,30,10,20 with random in_en gaps; mode_sel toggled mid-round -> outputs 10,10,20 with ranks 0,1,2. Mode change ignored. busy high 4 cycles.
- Defaults; in_en=1 during the busy window with byte 0xAA -> byte dropped; the next round's first word LSB equals the first byte sent after busy falls.
- Defaults; assert rst during DRAIN after rank0 -> valid=0 and busy=1 immediately. A new round after release reports only new-round data.
